// File: rtl/pcs_10g_block_lock.sv
// 10GBASE-R receive block-lock controller.
// Examines the sync header of each 66-bit block coming from the RX gearbox,
// requests single-bit gearbox slips until a full window of clean headers is
// seen, and forwards blocks to the descrambler only while lock is held.
module pcs_10g_block_lock #(
    parameter int SH_CNT_MAX     = 64,  // valid-flagged blocks per test window
    parameter int SH_INVALID_MAX = 16,  // invalid headers per window that drop lock
    parameter int SLIP_WAIT      = 32,  // cycles of ignored input after a slip (>=1)
    parameter int SLIP_CNT_W     = 16   // width of the saturating slip counter
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [65:0]           rx_block_in,
    input  logic                  rx_block_valid,
    output logic                  slip,
    output logic                  block_lock,
    output logic [65:0]           rx_block_out,
    output logic                  rx_block_out_valid,
    output logic [SLIP_CNT_W-1:0] slip_count
);

    localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_TEST = 2'd0,  // evaluating headers
        ST_SLIP = 2'd1,  // one-cycle slip request
        ST_WAIT = 2'd2   // gearbox settling, input ignored
    } state_t;

    state_t             state, state_next;
    logic [SH_W-1:0]    sh_cnt, sh_cnt_next;
    logic [INV_W-1:0]   sh_inv_cnt, sh_inv_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_next;
    logic               lock_next;

    logic               sh_valid;
    logic               window_end;
    logic               inv_limit;

    // 01 and 10 are the only legal sync headers: exactly one bit set.
    assign sh_valid   = rx_block_in[65] ^ rx_block_in[64];
    // sh_cnt holds blocks already seen this window, so the current block is the last one.
    assign window_end = (sh_cnt == SH_W'(SH_CNT_MAX - 1));
    // This invalid header would be the one that exhausts the per-window budget.
    assign inv_limit  = (sh_inv_cnt == INV_W'(SH_INVALID_MAX - 1));

    // Next-state, counter and lock decisions.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_next      = state;
        sh_cnt_next     = sh_cnt;
        sh_inv_cnt_next = sh_inv_cnt;
        wait_cnt_next   = wait_cnt;
        lock_next       = block_lock;

        case (state)
            ST_TEST: begin
                if (rx_block_valid) begin
                    if (!sh_valid && (!block_lock || inv_limit)) begin
                        // Loss of lock wins over a coincident window end.
                        state_next = ST_SLIP;
                        lock_next  = 1'b0;
                    end else if (window_end) begin
                        sh_cnt_next     = '0;
                        sh_inv_cnt_next = '0;
                        if (sh_valid && (sh_inv_cnt == '0)) begin
                            lock_next = 1'b1;
                        end
                    end else begin
                        sh_cnt_next = sh_cnt + 1'b1;
                        if (!sh_valid) begin
                            sh_inv_cnt_next = sh_inv_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_SLIP: begin
                lock_next       = 1'b0;
                sh_cnt_next     = '0;
                sh_inv_cnt_next = '0;
                wait_cnt_next   = '0;
                state_next      = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                    wait_cnt_next   = '0;
                    sh_cnt_next     = '0;
                    sh_inv_cnt_next = '0;
                    state_next      = ST_TEST;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_TEST;
            end
        endcase
    end

    // Control state, lock flag, slip pulse and saturating slip counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_TEST;
            sh_cnt     <= '0;
            sh_inv_cnt <= '0;
            wait_cnt   <= '0;
            block_lock <= 1'b0;
            slip       <= 1'b0;
            slip_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state      <= state_next;
            sh_cnt     <= sh_cnt_next;
            sh_inv_cnt <= sh_inv_cnt_next;
            wait_cnt   <= wait_cnt_next;
            block_lock <= lock_next;
            // Registered so the pulse is high exactly for the cycle spent in ST_SLIP.
            slip       <= (state_next == ST_SLIP);
            if ((state_next == ST_SLIP) && (slip_count != '1)) begin
                slip_count <= slip_count + 1'b1;
            end
        end
    end

    // One-cycle forwarding register toward the descrambler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset as well because every output must read zero during reset.
            rx_block_out       <= '0;
            rx_block_out_valid <= 1'b0;
        end else begin
            if (rx_block_valid) begin
                rx_block_out <= rx_block_in;
            end
            // lock_next makes the lock-completing block visible and suppresses the lock-losing one.
            rx_block_out_valid <= rx_block_valid && (state == ST_TEST) && lock_next;
        end
    end

endmodule

// File: tb/tb_pcs_10g_block_lock.sv
// Self-checking bench for pcs_10g_block_lock.
// A window/budget reference model predicts every output cycle by cycle; each
// scenario task adds directed checks at its points of interest. A second
// instance with a 2-bit slip counter shares the stimulus to exercise saturation.
module tb_pcs_10g_block_lock;

    localparam int SH_CNT_MAX     = 64;
    localparam int SH_INVALID_MAX = 16;
    localparam int SLIP_WAIT      = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [65:0] rx_block_in = '0;
    logic        rx_block_valid = 1'b0;

    logic        slip, block_lock, rx_block_out_valid;
    logic [65:0] rx_block_out;
    logic [15:0] slip_count;

    logic        sat_slip, sat_block_lock, sat_rx_block_out_valid;
    logic [65:0] sat_rx_block_out;
    logic [1:0]  sat_slip_count;

    int checks = 0;
    int fails  = 0;

    // Reference model state: window position, invalid budget used, blind cycles left.
    bit          m_lock;
    int          m_n, m_inv, m_blind, m_slips;
    bit          e_slip, e_ov;
    logic [65:0] e_out;

    int cyc = 0;
    int last_slip_cyc = -1;
    int seen_slips = 0;

    pcs_10g_block_lock #(
        .SH_CNT_MAX(SH_CNT_MAX), .SH_INVALID_MAX(SH_INVALID_MAX),
        .SLIP_WAIT(SLIP_WAIT), .SLIP_CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_block_in(rx_block_in), .rx_block_valid(rx_block_valid),
        .slip(slip), .block_lock(block_lock),
        .rx_block_out(rx_block_out), .rx_block_out_valid(rx_block_out_valid),
        .slip_count(slip_count)
    );

    pcs_10g_block_lock #(
        .SH_CNT_MAX(SH_CNT_MAX), .SH_INVALID_MAX(SH_INVALID_MAX),
        .SLIP_WAIT(SLIP_WAIT), .SLIP_CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .rx_block_in(rx_block_in), .rx_block_valid(rx_block_valid),
        .slip(sat_slip), .block_lock(sat_block_lock),
        .rx_block_out(sat_rx_block_out), .rx_block_out_valid(sat_rx_block_out_valid),
        .slip_count(sat_slip_count)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] mk(input bit good);
        logic [1:0] sh;
        if (good) sh = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        else      sh = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
        return {sh, $urandom(), $urandom()};
    endfunction

    function automatic logic [65:0] mk_sh(input logic [1:0] sh);
        return {sh, $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_lock = 1'b0; m_n = 0; m_inv = 0; m_blind = 0; m_slips = 0;
        e_slip = 1'b0; e_ov = 1'b0; e_out = '0;
        last_slip_cyc = -1; seen_slips = 0;
    endtask

    // Applies the block-lock rules to one clock edge's inputs.
    task automatic model_step(input bit v, input logic [65:0] blk);
        bit good;
        int n;
        e_slip = 1'b0;
        e_ov   = 1'b0;
        if (v) e_out = blk;
        if (m_blind > 0) begin
            m_blind--;
        end else if (v) begin
            good = (blk[65] != blk[64]);
            n = m_n + 1;
            if (!good && (!m_lock || (m_inv + 1 == SH_INVALID_MAX))) begin
                m_lock = 1'b0; m_n = 0; m_inv = 0;
                m_blind = SLIP_WAIT + 1;
                e_slip = 1'b1;
                m_slips++;
            end else if (n == SH_CNT_MAX) begin
                if (good && m_inv == 0) m_lock = 1'b1;
                m_n = 0; m_inv = 0;
                e_ov = m_lock;
            end else begin
                m_n = n;
                if (!good) m_inv++;
                e_ov = m_lock;
            end
        end
    endtask

    // Drives one cycle, advances the model, and compares all outputs 1 time unit after the edge.
    task automatic cycle(input bit v, input logic [65:0] blk);
        logic [1:0] exp_sat;
        rx_block_valid = v;
        rx_block_in    = blk;
        @(posedge clk);
        model_step(v, blk);
        cyc++;
        #1;
        exp_sat = (m_slips > 3) ? 2'd3 : 2'(m_slips);
        checks++;
        if (slip !== e_slip) begin
            fails++; $display("FAIL slip cyc=%0d: got %b expected %b", cyc, slip, e_slip);
        end
        checks++;
        if (block_lock !== m_lock) begin
            fails++; $display("FAIL block_lock cyc=%0d: got %b expected %b", cyc, block_lock, m_lock);
        end
        checks++;
        if (rx_block_out_valid !== e_ov) begin
            fails++; $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, rx_block_out_valid, e_ov);
        end
        checks++;
        if (rx_block_out !== e_out) begin
            fails++; $display("FAIL out_data cyc=%0d: got %h expected %h", cyc, rx_block_out, e_out);
        end
        checks++;
        if (slip_count !== 16'(m_slips)) begin
            fails++; $display("FAIL slip_count cyc=%0d: got %0d expected %0d", cyc, slip_count, m_slips);
        end
        checks++;
        if (sat_slip_count !== exp_sat) begin
            fails++; $display("FAIL sat_slip_count cyc=%0d: got %0d expected %0d", cyc, sat_slip_count, exp_sat);
        end
        if (slip === 1'b1) begin
            seen_slips++;
            if (last_slip_cyc >= 0) begin
                checks++;
                if (cyc - last_slip_cyc < SLIP_WAIT + 2) begin
                    fails++; $display("FAIL slip_spacing cyc=%0d: got %0d expected >=%0d", cyc, cyc - last_slip_cyc, SLIP_WAIT + 2);
                end
            end
            last_slip_cyc = cyc;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rx_block_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({slip, block_lock, rx_block_out_valid, rx_block_out, slip_count} !== '0) begin
            fails++; $display("FAIL reset_outputs: got %b/%b/%b/%h/%0d expected all 0", slip, block_lock, rx_block_out_valid, rx_block_out, slip_count);
        end
        apply_reset();
    endtask

    // Scenario 1: 64 clean blocks acquire lock; block 64 is the first forwarded.
    task automatic test_acquire();
        for (int i = 1; i <= SH_CNT_MAX; i++) begin
            cycle(1'b1, mk(1'b1));
            if (i == SH_CNT_MAX - 1) begin
                checks++;
                if (block_lock !== 1'b0 || rx_block_out_valid !== 1'b0) begin
                    fails++; $display("FAIL acquire_early: got lock=%b ov=%b expected 0/0", block_lock, rx_block_out_valid);
                end
            end
        end
        checks++;
        if (block_lock !== 1'b1 || rx_block_out_valid !== 1'b1) begin
            fails++; $display("FAIL acquire_lock: got lock=%b ov=%b expected 1/1", block_lock, rx_block_out_valid);
        end
        checks++;
        if (seen_slips != 0) begin
            fails++; $display("FAIL acquire_no_slip: got %0d slips expected 0", seen_slips);
        end
    endtask

    // Scenario 4: one invalid header per window (with random idle gaps) never costs lock.
    task automatic test_window_errors();
        int pos;
        for (int w = 0; w < 10; w++) begin
            pos = int'($urandom_range(1, SH_CNT_MAX));
            for (int i = 1; i <= SH_CNT_MAX; i++) begin
                if ($urandom_range(0, 3) == 0) cycle(1'b0, mk(1'b0));
                cycle(1'b1, mk(i != pos));
                if (i == pos) begin
                    checks++;
                    if (rx_block_out_valid !== 1'b1) begin
                        fails++; $display("FAIL invalid_forwarded win=%0d: got %b expected 1", w, rx_block_out_valid);
                    end
                end
            end
            checks++;
            if (block_lock !== 1'b1) begin
                fails++; $display("FAIL window_lock_held win=%0d: got %b expected 1", w, block_lock);
            end
        end
        checks++;
        if (slip_count !== 16'd0) begin
            fails++; $display("FAIL window_slip_count: got %0d expected 0", slip_count);
        end
    endtask

    // Scenario 3: 15 invalids in one window hold lock; 16th invalid at block 40 of the next drops it.
    task automatic test_lock_loss();
        bit bad [1:39];
        int nbad;
        int p;
        for (int i = 1; i <= SH_CNT_MAX; i++) begin
            cycle(1'b1, (i <= SH_INVALID_MAX - 1) ? mk_sh(2'b11) : mk(1'b1));
        end
        checks++;
        if (block_lock !== 1'b1) begin
            fails++; $display("FAIL loss_window1_held: got %b expected 1", block_lock);
        end
        for (int i = 1; i <= 39; i++) bad[i] = 1'b0;
        nbad = 0;
        while (nbad < SH_INVALID_MAX - 1) begin
            p = int'($urandom_range(1, 39));
            if (!bad[p]) begin
                bad[p] = 1'b1;
                nbad++;
            end
        end
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b1, (i == 40) ? mk(1'b0) : mk(!bad[i]));
            if (i == 39) begin
                checks++;
                if (block_lock !== 1'b1) begin
                    fails++; $display("FAIL loss_before_40: got %b expected 1", block_lock);
                end
            end
        end
        checks++;
        if (block_lock !== 1'b0 || slip !== 1'b1 || rx_block_out_valid !== 1'b0) begin
            fails++; $display("FAIL loss_at_40: got lock=%b slip=%b ov=%b expected 0/1/0", block_lock, slip, rx_block_out_valid);
        end
    endtask

    // Scenario 2: unlocked, a bad header at block 10 slips once; blocks during the blind period are dropped.
    task automatic test_slip_unlocked();
        for (int i = 0; i < SLIP_WAIT + 1; i++) cycle(1'b1, mk($urandom_range(0, 1) == 1));
        for (int i = 1; i <= 10; i++) cycle(1'b1, (i == 10) ? mk_sh(2'b00) : mk(1'b1));
        checks++;
        if (slip !== 1'b1 || slip_count !== 16'd2) begin
            fails++; $display("FAIL unlocked_slip: got slip=%b count=%0d expected 1/2", slip, slip_count);
        end
        for (int i = 0; i < SLIP_WAIT + 1; i++) begin
            cycle(1'b1, mk($urandom_range(0, 1) == 1));
            checks++;
            if (slip !== 1'b0 || rx_block_out_valid !== 1'b0) begin
                fails++; $display("FAIL blind_drop i=%0d: got slip=%b ov=%b expected 0/0", i, slip, rx_block_out_valid);
            end
        end
        for (int i = 1; i <= SH_CNT_MAX; i++) cycle(1'b1, mk(1'b1));
        checks++;
        if (block_lock !== 1'b1) begin
            fails++; $display("FAIL unlocked_reacquire: got %b expected 1", block_lock);
        end
    endtask

    // Continuous invalid stream: slips at the minimum spacing, 2-bit counter saturates at the 5th.
    task automatic test_back_to_back();
        int slip_cyc[$];
        int t0;
        int start;
        t0 = cyc;
        start = seen_slips;
        for (int i = 0; i < 300 && seen_slips < start + 4; i++) begin
            cycle(1'b1, mk(1'b0));
            if (slip === 1'b1) begin
                slip_cyc.push_back(cyc);
                if (seen_slips == 5) begin
                    checks++;
                    if (sat_slip_count !== 2'd3 || slip_count !== 16'd5) begin
                        fails++; $display("FAIL saturation_5th: got sat=%0d full=%0d expected 3/5", sat_slip_count, slip_count);
                    end
                end
            end
        end
        checks++;
        if (slip_cyc.size() != 4) begin
            fails++; $display("FAIL b2b_slip_budget: got %0d slips expected 4", slip_cyc.size());
        end else begin
            checks++;
            if (slip_cyc[0] - t0 != SH_INVALID_MAX) begin
                fails++; $display("FAIL b2b_first_slip: got block %0d expected %0d", slip_cyc[0] - t0, SH_INVALID_MAX);
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (slip_cyc[k] - slip_cyc[k-1] != SLIP_WAIT + 2) begin
                    fails++; $display("FAIL b2b_spacing k=%0d: got %0d expected %0d", k, slip_cyc[k] - slip_cyc[k-1], SLIP_WAIT + 2);
                end
            end
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, mk(1'b0));
    endtask

    // Scenario 6: asynchronous reset in the middle of WAIT clears everything at once.
    task automatic test_reset_mid_wait();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({slip, block_lock, rx_block_out_valid, rx_block_out, slip_count} !== '0) begin
            fails++; $display("FAIL async_reset: got %b/%b/%b/%h/%0d expected all 0", slip, block_lock, rx_block_out_valid, rx_block_out, slip_count);
        end
        checks++;
        if (sat_slip_count !== 2'd0) begin
            fails++; $display("FAIL async_reset_sat: got %0d expected 0", sat_slip_count);
        end
        apply_reset();
        for (int i = 1; i <= SH_CNT_MAX; i++) cycle(1'b1, mk(1'b1));
        checks++;
        if (block_lock !== 1'b1 || seen_slips != 0 || slip_count !== 16'd0) begin
            fails++; $display("FAIL reset_reacquire: got lock=%b slips=%0d count=%0d expected 1/0/0", block_lock, seen_slips, slip_count);
        end
    endtask

    // Scenario 5: valid toggling 1/0; idle cycles freeze the window, lock after the 64th valid block.
    task automatic test_toggle_valid();
        apply_reset();
        for (int c = 1; c <= 2 * SH_CNT_MAX; c++) begin
            cycle((c % 2) == 1, mk(1'b1));
            if (c == SH_CNT_MAX || c == 2 * SH_CNT_MAX - 2) begin
                checks++;
                if (block_lock !== 1'b0) begin
                    fails++; $display("FAIL toggle_early c=%0d: got %b expected 0", c, block_lock);
                end
            end
            if (c == 2 * SH_CNT_MAX - 1) begin
                checks++;
                if (block_lock !== 1'b1 || rx_block_out_valid !== 1'b1) begin
                    fails++; $display("FAIL toggle_lock: got lock=%b ov=%b expected 1/1", block_lock, rx_block_out_valid);
                end
            end
        end
        checks++;
        if (rx_block_out_valid !== 1'b0) begin
            fails++; $display("FAIL toggle_idle_ov: got %b expected 0", rx_block_out_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_acquire();
        test_window_errors();
        test_lock_loss();
        test_slip_unlocked();
        test_back_to_back();
        test_reset_mid_wait();
        test_toggle_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
